// File: rtl/smart_outport_arbiter_pkg.sv
// Shared types and constants for the SMART router output-port scheduler.
// The ARB_FIXED_PRIORITY_EN macro selects fixed-priority arbitration instead of round-robin.
package smart_outport_arbiter_pkg;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        SOUTH = 3'd1,
        WEST  = 3'd2,
        NORTH = 3'd3,
        LOCAL = 3'd4
    } Direction;

    localparam int NUM_DIRECTIONS       = 5;
    localparam int RT_FLIT_SIZE         = 17;
    localparam int OUTPORT_CREDIT_DEPTH = 4;

    typedef logic [$clog2(NUM_DIRECTIONS)-1:0]         ArbReqId;
    typedef logic [$clog2(OUTPORT_CREDIT_DEPTH+1)-1:0] CreditCount;

    // Next round-robin start index: one past the winner, wrapping to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/smart_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr_i (ArbiterType RR) by default,
// or lowest-index-wins (ArbiterType FIXED) when ARB_FIXED_PRIORITY_EN is defined.
module smart_rr_arbiter
    import smart_outport_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = NUM_DIRECTIONS,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      winner_o
);

    logic [IW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;
    int            sum_s;

    // Scan requesters in priority order; the first pending one wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        idx_s    = '0;
        sum_s    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            sum_s = i;
`else
            sum_s = (int'(ptr_i) + i >= NUM_REQ) ? int'(ptr_i) + i - NUM_REQ : int'(ptr_i) + i;
`endif
            idx_s          = IW'(sum_s);
            hit_s          = req_i[idx_s] & ~found_s;
            grant_o[idx_s] = grant_o[idx_s] | hit_s;
            winner_o       = hit_s ? idx_s : winner_o;
            found_s        = found_s | hit_s;
        end
    end

endmodule

// File: rtl/smart_outport_arbiter.sv
// Output-port scheduler: arbitrates NUM_REQ requesters onto one registered link under
// downstream credit flow control. ARB_FIXED_PRIORITY_EN removes the round-robin pointer.
module smart_outport_arbiter
    import smart_outport_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = NUM_DIRECTIONS,
    parameter  int DATA_WIDTH = RT_FLIT_SIZE,
    parameter  int BUF_DEPTH  = OUTPORT_CREDIT_DEPTH,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW         = $clog2(BUF_DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_flit,
    output logic [NUM_REQ-1:0]                  req_grant,
    output logic                                out_valid,
    output logic [DATA_WIDTH-1:0]               out_flit,
    output logic [IW-1:0]                       out_src,
    input  logic                                credit_in,
    output logic [CW-1:0]                       credit_count,
    output logic                                credit_err
);

    logic [NUM_REQ-1:0]    arb_grant_s;
    logic [IW-1:0]         arb_winner_s;
    logic [IW-1:0]         ptr_s;
    logic                  grant_s;
    logic [CW-1:0]         credit_q, credit_d;
    logic                  credit_err_q, credit_err_d;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_flit_q;
    logic [IW-1:0]         out_src_q;

    smart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i    (req_valid),
        .ptr_i    (ptr_s),
        .grant_o  (arb_grant_s),
        .winner_o (arb_winner_s)
    );

    // Only the registered credit count gates a grant; a same-cycle credit_in does not.
    assign grant_s   = ~reset & enable & (|req_valid) & (credit_q != '0);
    assign req_grant = grant_s ? arb_grant_s : '0;

`ifdef ARB_FIXED_PRIORITY_EN
    assign ptr_s = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;

    assign ptr_d = grant_s ? IW'(wrap_inc(int'(arb_winner_s), NUM_REQ)) : ptr_q;
    assign ptr_s = ptr_q;

    // Round-robin start pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Credit update; a return while already full saturates and flags an error.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        case ({grant_s, credit_in})
            2'b10: begin
                credit_d = credit_q - CW'(1);
            end
            2'b01: begin
                if (credit_q == CW'(BUF_DEPTH)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            default: begin
                credit_d = credit_q;
            end
        endcase
    end

    // Credit counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q     <= CW'(BUF_DEPTH);
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Link output register; flit and source hold when no grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= grant_s;
            if (grant_s) begin
                out_flit_q <= req_flit[arb_winner_s];
                out_src_q  <= arb_winner_s;
            end else begin
                out_flit_q <= out_flit_q;
                out_src_q  <= out_src_q;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_flit     = out_flit_q;
    assign out_src      = out_src_q;
    assign credit_count = credit_q;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_smart_outport_arbiter.sv
// Directed self-checking bench for smart_outport_arbiter (expectations follow ARB_FIXED_PRIORITY_EN).
module tb_smart_outport_arbiter;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [4:0]       req_valid;
    logic [4:0][16:0] req_flit;
    logic [4:0]       req_grant;
    logic             out_valid;
    logic [16:0]      out_flit;
    logic [2:0]       out_src;
    logic             credit_in;
    logic [2:0]       credit_count;
    logic             credit_err;

    int checks   = 0;
    int failures = 0;
    logic [16:0] flit_tab [5];

    smart_outport_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_flit     (req_flit),
        .req_grant    (req_grant),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_src      (out_src),
        .credit_in    (credit_in),
        .credit_count (credit_count),
        .credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req_valid = 5'b00000; credit_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (credit_count !== 3'd4) begin failures++; $display("FAIL reset_credit got=%0d exp=4", credit_count); end
        checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", credit_err); end
        checks++; if (req_grant !== 5'b00000) begin failures++; $display("FAIL reset_grant got=%b exp=00000", req_grant); end
        checks++; if (out_src !== 3'd0 || out_flit !== 17'h0) begin failures++; $display("FAIL reset_out got src=%0d flit=%h exp 0/0", out_src, out_flit); end
    endtask

    task automatic test_alternate();
        logic [2:0] exp_src;
        for (int c = 0; c < 4; c++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            exp_src = 3'd0;
`else
            exp_src = (c % 2 == 0) ? 3'd0 : 3'd4;
`endif
            @(negedge clk); req_valid = 5'b10001; credit_in = 1'b1; #1;
            checks++; if (req_grant !== (5'b00001 << exp_src)) begin failures++; $display("FAIL alt_grant cyc=%0d got=%b exp_idx=%0d", c, req_grant, exp_src); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_src !== exp_src) begin failures++; $display("FAIL alt_out cyc=%0d got v=%b src=%0d exp v=1 src=%0d", c, out_valid, out_src, exp_src); end
            checks++; if (out_flit !== flit_tab[exp_src]) begin failures++; $display("FAIL alt_flit cyc=%0d got=%h exp=%h", c, out_flit, flit_tab[exp_src]); end
            checks++; if (credit_count !== 3'd4) begin failures++; $display("FAIL alt_credit cyc=%0d got=%0d exp=4", c, credit_count); end
        end
        @(negedge clk); req_valid = 5'b00000; credit_in = 1'b0;
        checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL alt_err got=%b exp=0", credit_err); end
    endtask

    task automatic test_credit_drain();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); req_valid = 5'b00100; #1;
            checks++; if (req_grant !== 5'b00100) begin failures++; $display("FAIL drain_grant cyc=%0d got=%b exp=00100", c, req_grant); end
            @(posedge clk); #1;
            checks++; if (credit_count !== 3'(3 - c)) begin failures++; $display("FAIL drain_credit cyc=%0d got=%0d exp=%0d", c, credit_count, 3 - c); end
            checks++; if (out_valid !== 1'b1 || out_src !== 3'd2 || out_flit !== flit_tab[2]) begin failures++; $display("FAIL drain_out cyc=%0d got v=%b src=%0d flit=%h", c, out_valid, out_src, out_flit); end
        end
        @(negedge clk); #1;
        checks++; if (req_grant !== 5'b00000) begin failures++; $display("FAIL empty_grant got=%b exp=00000", req_grant); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || credit_count !== 3'd0 || out_src !== 3'd2) begin failures++; $display("FAIL empty_out got v=%b cnt=%0d src=%0d exp 0/0/2", out_valid, credit_count, out_src); end
        @(negedge clk); credit_in = 1'b1; #1;
        checks++; if (req_grant !== 5'b00000) begin failures++; $display("FAIL same_cycle_credit_grant got=%b exp=00000", req_grant); end
        @(posedge clk); #1;
        checks++; if (credit_count !== 3'd1 || out_valid !== 1'b0) begin failures++; $display("FAIL credit_return got cnt=%0d v=%b exp 1/0", credit_count, out_valid); end
        @(negedge clk); credit_in = 1'b0; #1;
        checks++; if (req_grant !== 5'b00100) begin failures++; $display("FAIL regrant got=%b exp=00100", req_grant); end
        @(posedge clk); #1;
        checks++; if (credit_count !== 3'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL regrant_out got cnt=%0d v=%b exp 0/1", credit_count, out_valid); end
        @(negedge clk); req_valid = 5'b00000; credit_in = 1'b1;
        repeat (4) @(posedge clk);
        #1; credit_in = 1'b0;
        checks++; if (credit_count !== 3'd4 || credit_err !== 1'b0) begin failures++; $display("FAIL refill got cnt=%0d err=%b exp 4/0", credit_count, credit_err); end
    endtask

    task automatic test_enable();
        logic [2:0] exp_a, exp_b;
`ifdef ARB_FIXED_PRIORITY_EN
        exp_a = 3'd0; exp_b = 3'd0;
`else
        exp_a = 3'd3; exp_b = 3'd4;
`endif
        @(negedge clk); enable = 1'b0; req_valid = 5'b11111; #1;
        checks++; if (req_grant !== 5'b00000) begin failures++; $display("FAIL disabled_grant got=%b exp=00000", req_grant); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || credit_count !== 3'd4) begin failures++; $display("FAIL disabled_out got v=%b cnt=%0d exp 0/4", out_valid, credit_count); end
        @(negedge clk); enable = 1'b1; #1;
        checks++; if (req_grant !== (5'b00001 << exp_a)) begin failures++; $display("FAIL ptr_keep_grant got=%b exp_idx=%0d", req_grant, exp_a); end
        @(posedge clk); #1;
        checks++; if (out_src !== exp_a || credit_count !== 3'd3) begin failures++; $display("FAIL ptr_keep_out got src=%0d cnt=%0d exp %0d/3", out_src, credit_count, exp_a); end
        @(negedge clk); #1;
        checks++; if (req_grant !== (5'b00001 << exp_b)) begin failures++; $display("FAIL b2b_grant got=%b exp_idx=%0d", req_grant, exp_b); end
        @(posedge clk); #1;
        checks++; if (out_src !== exp_b || out_flit !== flit_tab[exp_b] || credit_count !== 3'd2) begin failures++; $display("FAIL b2b_out got src=%0d flit=%h cnt=%0d", out_src, out_flit, credit_count); end
        @(negedge clk); req_valid = 5'b00000; credit_in = 1'b1;
        repeat (2) @(posedge clk);
        #1; credit_in = 1'b0;
        checks++; if (credit_count !== 3'd4 || credit_err !== 1'b0) begin failures++; $display("FAIL enable_refill got cnt=%0d err=%b exp 4/0", credit_count, credit_err); end
    endtask

    task automatic test_overflow();
        @(negedge clk); credit_in = 1'b1;
        @(posedge clk); #1;
        credit_in = 1'b0;
        checks++; if (credit_count !== 3'd4 || credit_err !== 1'b1) begin failures++; $display("FAIL overflow got cnt=%0d err=%b exp 4/1", credit_count, credit_err); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (credit_err !== 1'b1 || credit_count !== 3'd4) begin failures++; $display("FAIL overflow_sticky got err=%b cnt=%0d exp 1/4", credit_err, credit_count); end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); req_valid = 5'b00010;
            @(posedge clk); #1;
        end
        checks++; if (credit_count !== 3'd1 || out_valid !== 1'b1 || out_src !== 3'd1) begin failures++; $display("FAIL pre_reset got cnt=%0d v=%b src=%0d exp 1/1/1", credit_count, out_valid, out_src); end
        #2; reset = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || credit_count !== 3'd4 || credit_err !== 1'b0) begin failures++; $display("FAIL async_reset got v=%b cnt=%0d err=%b exp 0/4/0", out_valid, credit_count, credit_err); end
        checks++; if (out_flit !== 17'h0 || out_src !== 3'd0 || req_grant !== 5'b00000) begin failures++; $display("FAIL async_reset_out got flit=%h src=%0d grant=%b", out_flit, out_src, req_grant); end
        @(negedge clk); reset = 1'b0; req_valid = 5'b11111; #1;
        checks++; if (req_grant !== 5'b00001) begin failures++; $display("FAIL restart_grant got=%b exp=00001", req_grant); end
        @(posedge clk); #1;
        checks++; if (out_src !== 3'd0 || out_flit !== flit_tab[0] || credit_count !== 3'd3) begin failures++; $display("FAIL restart_out got src=%0d flit=%h cnt=%0d", out_src, out_flit, credit_count); end
        @(negedge clk); req_valid = 5'b00000;
    endtask

    initial begin
        flit_tab[0] = 17'h10001;
        flit_tab[1] = 17'h02222;
        flit_tab[2] = 17'h03333;
        flit_tab[3] = 17'h04444;
        flit_tab[4] = 17'h15555;
        for (int i = 0; i < 5; i++) req_flit[i] = flit_tab[i];
        reset = 1'b1; enable = 1'b1; req_valid = 5'b00000; credit_in = 1'b0;
        test_reset();
        test_alternate();
        test_credit_drain();
        test_enable();
        test_overflow();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smart_outport_arbiter.md
Name: smart_outport_arbiter

Overview:
- Output-port scheduler for one SMART router output direction (EAST/SOUTH/WEST/NORTH/LOCAL).
- Shares a single outgoing FlitFixed link among NUM_REQ input-direction requesters.
- Enforces downstream buffer credit flow control.
- Registers the winning flit onto the link and tracks credits returned by the downstream router.

Parameters:
- NUM_REQ, 5, number of requesting input directions; index = SMARTPkg Direction encoding, LOCAL last.
- DATA_WIDTH, `RT_FLIT_SIZE (17), FlitFixed data width.
- BUF_DEPTH, 4, downstream input-buffer depth = initial credit count; must be >= 1.

Ports:
- clk  in  1  router clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  when 0, no new grants are issued; in-flight output still completes
- req_valid  in  NUM_REQ  per-requester flit-pending flag
- req_flit  in  NUM_REQ x DATA_WIDTH  per-requester FlitFixed data
- req_grant  out  NUM_REQ  one-hot, combinational; requester pops its flit this cycle
- out_valid  out  1  registered flit-valid to link
- out_flit  out  DATA_WIDTH  registered flit to link
- out_src  out  $clog2(NUM_REQ)  registered index of the granted requester
- credit_in  in  1  Credit pulse from downstream; one buffer slot freed per cycle high
- credit_count  out  $clog2(BUF_DEPTH+1)  current available credits
- credit_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset values:
  - out_valid=0, out_flit=0, out_src=0, req_grant=0.
  - credit_count=BUF_DEPTH, credit_err=0.
  - RR pointer=0.
- Grant condition: enable & |req_valid & (credit_count != 0). Otherwise req_grant=0.
- Credit usage: credit_in in the same cycle does NOT enable a grant at credit_count==0; only the registered count is used.
- Arbitration (default): round-robin.
  - Search starts at index ptr and wraps modulo NUM_REQ.
  - First valid requester wins.
  - On grant, ptr <= winner+1, wrapping NUM_REQ-1 -> 0.
  - ptr is unchanged when no grant is issued.
- Latency: on a grant in cycle N, out_valid=1, out_flit=req_flit[winner] and out_src=winner appear in cycle N+1. With no grant, out_valid=0 next cycle and out_flit/out_src hold their previous values.
- Throughput: one flit per cycle while credits remain. Back-to-back grants to different requesters are allowed.
- Credit counter, per cycle:
  - grant & ~credit_in: decrement.
  - ~grant & credit_in: increment.
  - grant & credit_in: unchanged.
  - neither: unchanged.
- Credit boundaries:
  - If credit_in arrives with credit_count==BUF_DEPTH and no grant, the counter saturates at BUF_DEPTH and credit_err is set.
  - The decrement path can never underflow, because a grant requires credit_count>0.
  - credit_err clears only on reset.
- enable deassert: takes effect the same cycle (no grant). ptr and the credit counter keep their state; credit_in is still accepted.
- Reset mid-operation: any flit registered but not yet observed is dropped, and credits return to BUF_DEPTH. The downstream router is reset together with this block.
- req_valid dropped without a grant is legal; no state is kept per requester.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins (EAST highest, LOCAL lowest). ptr logic is removed.
- Undefined: round-robin as specified above.
- Credit, latency and reset behaviour are identical in both modes.

Decomposition:
- In SMARTPkg:
  - typedef ArbReqId = logic [$clog2(NUM_DIRECTIONS)-1:0].
  - localparam OUTPORT_CREDIT_DEPTH = 4.
  - typedef CreditCount = logic [$clog2(OUTPORT_CREDIT_DEPTH+1)-1:0].
- Reuse the TopPkg ArbiterType values in comments and documentation only; the mode is selected by the macro.
- One sub-module, smart_rr_arbiter:
  - purely combinational; inputs req vector and ptr; outputs one-hot grant and binary winner.
  - holds a fixed-priority variant under ARB_FIXED_PRIORITY_EN.
  - the parent owns ptr, the credit counter and the output register.

Test Plan:
1. Reset, then idle 3 cycles -> out_valid=0, credit_count=4, credit_err=0, req_grant=0.
2. req_valid=5'b10001 held, credit_in pulsed every cycle -> grants alternate 0,4,0,4. out_src follows one cycle later, with out_flit matching the requester data each cycle. Fixed-priority build: always 0.
3. req_valid=5'b00100, no credit_in -> four grants in cycles 1-4; credit_count 3,2,1,0; cycle 5 no grant with req still high. A credit_in pulse gives credit_count=1 and a grant the following cycle.
4. credit_count=0, credit_in=1 and req_valid=1 in the same cycle -> no grant that cycle; credit_count=1; grant next cycle; credit_count back to 0.
5. Idle at credit_count=4, credit_in pulse -> credit_count stays 4, credit_err=1 and remains set until reset.
6. Reset asserted asynchronously mid-stream with credit_count=1 and out_valid=1 -> outputs reach reset values immediately, without waiting for a clock edge. After release, RR restarts at index 0.
